// File: rtl/cpsr_flag_unit_pkg.sv
// Shared flag indices, masks and the capture-request record for the CPSR flag unit.
// Flag vectors use one bit ordering everywhere: N=0, Z=1, C=2, V=3.
package cpsr_flag_unit_pkg;

    localparam int NUM_FLAGS = 4;

    localparam int N_I = 0;
    localparam int Z_I = 1;
    localparam int C_I = 2;
    localparam int V_I = 3;

    localparam logic [NUM_FLAGS-1:0] FLAGMASK_NZ  = (4'b0001 << N_I) | (4'b0001 << Z_I);
    localparam logic [NUM_FLAGS-1:0] FLAGMASK_NZC = FLAGMASK_NZ | (4'b0001 << C_I);
    localparam logic [NUM_FLAGS-1:0] FLAGMASK_ALL = FLAGMASK_NZC | (4'b0001 << V_I);

    // One flag update: which flags it writes and their new values.
    typedef struct packed {
        logic                 valid;
        logic [NUM_FLAGS-1:0] mask;
        logic [NUM_FLAGS-1:0] flags;
    } flag_upd_t;

endpackage

// File: rtl/cpsr_flag_unit_flag_merge.sv
// Per-bit flag merge: masked bits take the new value, the rest keep the base.
// Used for both the forwarding path and the commit path.
module flag_merge
    import cpsr_flag_unit_pkg::*;
#(
    parameter int VEC_W = NUM_FLAGS
) (
    input  logic [VEC_W-1:0] base,
    input  logic [VEC_W-1:0] mask,
    input  logic [VEC_W-1:0] flags,
    output logic [VEC_W-1:0] merged
);

    for (genvar i = 0; i < VEC_W; i++) begin : g_bit
        assign merged[i] = mask[i] ? flags[i] : base[i];
    end

endmodule

// File: rtl/cpsr_flag_unit.sv
// Architectural N/Z/C/V flags plus the one in-flight update from EX, with a
// combinational forward so the next EX instruction sees its predecessor's flags.
module cpsr_flag_unit
    import cpsr_flag_unit_pkg::*;
#(
    parameter logic [NUM_FLAGS-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_in,
    input  logic                 flush_in,
    input  logic                 ex_valid_in,
    input  logic                 ex_setflags_in,
    input  logic                 ex_condpass_in,
    input  logic [NUM_FLAGS-1:0] ex_mask_in,
    input  logic [NUM_FLAGS-1:0] ex_flags_in,
    input  logic                 msr_we_in,
    input  logic [NUM_FLAGS-1:0] msr_flags_in,
    output logic [NUM_FLAGS-1:0] cpsr_out,
    output logic [NUM_FLAGS-1:0] cpsr_fwd_out,
    output logic                 pend_valid_out
);

    logic [NUM_FLAGS-1:0] arch;
    flag_upd_t            pend;
    flag_upd_t            cap;
    logic [NUM_FLAGS-1:0] fwd_merged;
    logic [NUM_FLAGS-1:0] commit_merged;

    // MSR outranks a normal flag setter issued in the same slot.
    always_comb begin
        cap = '0;
        if (msr_we_in) begin
            cap.valid = 1'b1;
            cap.mask  = FLAGMASK_ALL;
            cap.flags = msr_flags_in;
        end else if (ex_valid_in && ex_setflags_in && ex_condpass_in && (ex_mask_in != '0)) begin
            cap.valid = 1'b1;
            cap.mask  = ex_mask_in;
            cap.flags = ex_flags_in;
        end
    end

    flag_merge #(.VEC_W(NUM_FLAGS)) u_fwd_merge (
        .base   (arch),
        .mask   (pend.mask),
        .flags  (pend.flags),
        .merged (fwd_merged)
    );

    flag_merge #(.VEC_W(NUM_FLAGS)) u_commit_merge (
        .base   (arch),
        .mask   (pend.mask),
        .flags  (pend.flags),
        .merged (commit_merged)
    );

    // A flush still retires the pending update: it belongs to an older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch <= RESET_FLAGS;
            pend <= '0;
        end else if (flush_in) begin
            if (pend.valid) arch <= commit_merged;
            pend.valid <= 1'b0;
        end else if (!stall_in) begin
            if (pend.valid) arch <= commit_merged;
            pend.valid <= cap.valid;
            if (cap.valid) begin
                pend.mask  <= cap.mask;
                pend.flags <= cap.flags;
            end
        end
    end

    assign cpsr_out       = arch;
    assign cpsr_fwd_out   = pend.valid ? fwd_merged : arch;
    assign pend_valid_out = pend.valid;

endmodule
